// File: rtl/puf_stream_reader_if.sv
`default_nettype none
// ============================================================================
// puf_stream_reader_if : host UART link and PUF RAM read port bundle
// Revision: 1.0
// ============================================================================
interface puf_stream_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic              uart_rx_ready;
  logic [7:0]        uart_data_from_rx;
  logic              uart_tx_ready;
  logic [7:0]        uart_data_to_tx;
  logic              uart_tx_enable;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              err_cmd;

  modport slave (
    input  uart_rx_ready, uart_data_from_rx, uart_tx_ready, mem_rdata,
    output uart_data_to_tx, uart_tx_enable, mem_raddr, busy, err_cmd
  );

  modport master (
    output uart_rx_ready, uart_data_from_rx, uart_tx_ready, mem_rdata,
    input  uart_data_to_tx, uart_tx_enable, mem_raddr, busy, err_cmd
  );
endinterface
`default_nettype wire

// File: rtl/puf_stream_reader.sv
`default_nettype none
// ============================================================================
// puf_stream_reader : command-driven byte streamer from PUF SRAM to a UART
// Revision: 1.0
// ============================================================================
module puf_stream_reader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int NUM_BYTES = 16384,
  parameter int RD_LAT    = 1,
  parameter int CSUM_EN   = 1
) (
  input wire clk,
  input wire rst,
  puf_stream_reader_if.slave bus
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [15:0] C_LANES = 16'(LANES);
  localparam logic [16:0] C_NB17  = 17'(NUM_BYTES);
  localparam logic [2:0]  C_LAT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_MEM_WAIT, S_LOAD, S_SEND, S_WAIT_DONE, S_NEXT, S_CSUM
  } state_t;

  state_t            state_q;
  logic [15:0]       idx_q;
  logic [16:0]       end_q;
  logic [7:0]        csum_q;
  logic [23:0]       arg_q;
  logic [1:0]        argc_q;
  logic [2:0]        cnt_q;
  logic              seen_low_q;
  logic              is_csum_q;
  logic [7:0]        tx_data_q;
  logic              tx_en_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              err_q;

  logic [15:0]       start_d;
  logic [15:0]       len_d;
  logic [16:0]       sum_d;
  logic [16:0]       end_d;
  logic              start_bad_d;
  logic [15:0]       nidx_d;
  logic              last_d;
  logic [LANE_W-1:0] lane_d;
  logic [7:0]        byte_d;
  logic [7:0]        lanes_d [LANES];

  function automatic logic [ADDR_W-1:0] word_of(input logic [15:0] i);
    return ADDR_W'(i / C_LANES);
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lanes_d[g] = bus.mem_rdata[8*g +: 8];
  end

  // The 4th argument byte is still on the rx bus when the range is decided.
  assign start_d     = arg_q[23:8];
  assign len_d       = {arg_q[7:0], bus.uart_data_from_rx};
  assign sum_d       = {1'b0, start_d} + {1'b0, len_d};
  assign end_d       = (sum_d > C_NB17) ? C_NB17 : sum_d;
  assign start_bad_d = ({1'b0, start_d} >= C_NB17);
  assign nidx_d      = idx_q + 16'd1;
  assign last_d      = (({1'b0, idx_q} + 17'd1) == end_q);
  assign lane_d      = LANE_W'(idx_q % C_LANES);
  assign byte_d      = lanes_d[lane_d];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      end_q      <= '0;
      csum_q     <= '0;
      arg_q      <= '0;
      argc_q     <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      is_csum_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      raddr_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.uart_rx_ready) begin
            if (bus.uart_data_from_rx == 8'h73) begin
              idx_q   <= '0;
              end_q   <= C_NB17;
              csum_q  <= '0;
              raddr_q <= word_of(16'd0);
              cnt_q   <= '0;
              state_q <= S_MEM_WAIT;
            end else if (bus.uart_data_from_rx == 8'h72) begin
              argc_q  <= '0;
              state_q <= S_ARGS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ARGS: begin
          if (bus.uart_rx_ready) begin
            argc_q <= argc_q + 2'd1;
            arg_q  <= {arg_q[15:0], bus.uart_data_from_rx};
            if (argc_q == 2'd3) begin
              csum_q <= '0;
              if (start_bad_d) begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end else if (len_d == 16'd0) begin
                state_q <= (CSUM_EN != 0) ? S_CSUM : S_IDLE;
              end else begin
                idx_q   <= start_d;
                end_q   <= end_d;
                raddr_q <= word_of(start_d);
                cnt_q   <= '0;
                state_q <= S_MEM_WAIT;
              end
            end
          end
        end
        S_MEM_WAIT: begin
          if (cnt_q == C_LAT_LAST) state_q <= S_LOAD;
          else cnt_q <= cnt_q + 3'd1;
        end
        S_LOAD: begin
          if (bus.uart_tx_ready) begin
            tx_data_q <= byte_d;
            csum_q    <= csum_q + byte_d;
            tx_en_q   <= 1'b1;
            is_csum_q <= 1'b0;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          seen_low_q <= 1'b0;
          state_q    <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Only a low-then-high ready sequence marks the byte as gone.
          if (!bus.uart_tx_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            if (is_csum_q) begin
              csum_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (last_d) begin
            state_q <= (CSUM_EN != 0) ? S_CSUM : S_IDLE;
          end else begin
            idx_q   <= nidx_d;
            raddr_q <= word_of(nidx_d);
            cnt_q   <= '0;
            state_q <= S_MEM_WAIT;
          end
        end
        S_CSUM: begin
          if (bus.uart_tx_ready) begin
            tx_data_q <= csum_q;
            tx_en_q   <= 1'b1;
            is_csum_q <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_data_to_tx = tx_data_q;
  assign bus.uart_tx_enable  = tx_en_q;
  assign bus.mem_raddr       = raddr_q;
  assign bus.err_cmd         = err_q;
  assign bus.busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire
